// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types for the alu and the alu-sharing arbiter
package cpu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_MUL
  } aluFunc_t;
  typedef enum logic {ARB_IDLE, ARB_MULWAIT} arbState_t;
  localparam int N_ALU_REQ = 2;
endpackage

// File: rtl/alu.sv
// alu: combinational alu, result truncated to WIDTH
module alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  aluFunc_t         func,
  output logic [WIDTH-1:0] result
);
  always_comb begin
    result = '0;
    case (func)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b;
      ALU_SRL: result = a >> b;
      // low WIDTH bits of a product are identical for signed and unsigned operands
      ALU_MUL: result = a * b;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one alu between two requesters, with a multi-cycle MUL
module alu_share_arb
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_ALU_REQ-1:0]                req_valid,
  output logic [N_ALU_REQ-1:0]                req_ready,
  input  logic [N_ALU_REQ-1:0][WIDTH-1:0]     req_a,
  input  logic [N_ALU_REQ-1:0][WIDTH-1:0]     req_b,
  input  aluFunc_t [N_ALU_REQ-1:0]            req_func,
  output logic [N_ALU_REQ-1:0]                rsp_valid,
  output logic [WIDTH-1:0]                    rsp_result,
  output logic                                busy
);
  localparam int CW = $clog2(MUL_CYCLES) + 1;
  arbState_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic last_grant, g, accept, multi, cap, op_vld, op_id;
  logic [WIDTH-1:0] op_a, op_b, alu_result;
  aluFunc_t op_func;
  alu #(.WIDTH(WIDTH)) u_alu (
    .a(op_a),
    .b(op_b),
    .func(op_func),
    .result(alu_result)
  );
  assign busy = state == ARB_MULWAIT;
  always_comb begin
    g = (&req_valid) ? ~last_grant : req_valid[1];
    req_ready = (state == ARB_IDLE && |req_valid && !rst) ? N_ALU_REQ'(1) << g : '0;
    accept = |(req_valid & req_ready);
    multi = req_func[g] == ALU_MUL && MUL_CYCLES > 1;
    // the op held in the op regs is captured on the first cycle the alu is not stalled by a MUL
    cap = op_vld && state == ARB_IDLE;
    state_nxt = state;
    cnt_nxt = cnt;
    if (state == ARB_MULWAIT) begin
      cnt_nxt = cnt - CW'(1);
      state_nxt = cnt == CW'(1) ? ARB_IDLE : ARB_MULWAIT;
    end else if (accept && multi) begin
      cnt_nxt = CW'(MUL_CYCLES - 1);
      state_nxt = ARB_MULWAIT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_vld <= 1'b0;
      op_id <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      op_func <= ALU_ADD;
      rsp_valid <= '0;
      rsp_result <= '0;
    end else begin
      op_vld <= accept || (op_vld && !cap);
      rsp_valid <= cap ? N_ALU_REQ'(1) << op_id : '0;
      if (cap) rsp_result <= alu_result;
      if (accept) begin
        last_grant <= g;
        op_id <= g;
        op_a <= req_a[g];
        op_b <= req_b[g];
        op_func <= req_func[g];
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: table-driven arbitration vectors plus hand sequences, checked through a response scoreboard
module tb_alu_share_arb;
  import cpu_pkg::*;
  localparam int MC = 2;
  logic clk, rst;
  logic [1:0] req_valid, req_ready, rsp_valid;
  logic [1:0][7:0] req_a, req_b;
  aluFunc_t [1:0] req_func;
  logic [7:0] rsp_result;
  logic busy;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic id; logic [7:0] res; int due;} exp_t;
  exp_t sb[$];
  typedef struct {
    logic [1:0] v;
    aluFunc_t f0; logic [7:0] a0, b0;
    aluFunc_t f1; logic [7:0] a1, b1;
    logic [1:0] rdy; logic [7:0] res;
  } vec_t;
  vec_t tbl[12];
  alu_share_arb #(.WIDTH(8), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_func(req_func),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic expect_rsp(input logic id, input logic [7:0] res, input int lat);
    exp_t e;
    e.id = id; e.res = res; e.due = cyc + lat;
    sb.push_back(e);
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] v, input aluFunc_t f0, input logic [7:0] a0, b0,
                       input aluFunc_t f1, input logic [7:0] a1, b1);
    req_valid = v;
    req_func[0] = f0; req_a[0] = a0; req_b[0] = b0;
    req_func[1] = f1; req_a[1] = a1; req_b[1] = b1;
  endtask
  always @(negedge clk) begin
    if (rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {22'd0, rsp_valid, rsp_result}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", {22'd0, rsp_valid, rsp_result}, {22'd0, 2'b01 << e.id, e.res});
        chk("rsp_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("rsp_missing", 0, {23'd0, sb[0].id, sb[0].res});
      void'(sb.pop_front());
    end
    if (rst) sb.delete();
  end
  initial begin
    #200000;
    $display("FAIL timeout: no completion within time limit");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{2'b11, ALU_ADD, 8'h0A, 8'h05, ALU_ADD, 8'h10, 8'h10, 2'b01, 8'h0F};
    tbl[1]  = '{2'b11, ALU_ADD, 8'h01, 8'h01, ALU_ADD, 8'h10, 8'h10, 2'b10, 8'h20};
    tbl[2]  = '{2'b11, ALU_ADD, 8'h01, 8'h01, ALU_ADD, 8'h10, 8'h10, 2'b01, 8'h02};
    tbl[3]  = '{2'b11, ALU_ADD, 8'h01, 8'h01, ALU_ADD, 8'h10, 8'h10, 2'b10, 8'h20};
    tbl[4]  = '{2'b11, ALU_ADD, 8'h01, 8'h01, ALU_ADD, 8'h10, 8'h10, 2'b01, 8'h02};
    tbl[5]  = '{2'b00, ALU_ADD, 8'h01, 8'h01, ALU_ADD, 8'h10, 8'h10, 2'b00, 8'h00};
    tbl[6]  = '{2'b10, ALU_ADD, 8'h00, 8'h00, ALU_SUB, 8'h10, 8'h03, 2'b10, 8'h0D};
    tbl[7]  = '{2'b10, ALU_ADD, 8'h00, 8'h00, ALU_XOR, 8'hF0, 8'hFF, 2'b10, 8'h0F};
    tbl[8]  = '{2'b01, ALU_AND, 8'h3C, 8'h0F, ALU_ADD, 8'h00, 8'h00, 2'b01, 8'h0C};
    tbl[9]  = '{2'b11, ALU_OR,  8'h30, 8'h03, ALU_SLL, 8'h01, 8'h03, 2'b10, 8'h08};
    tbl[10] = '{2'b11, ALU_OR,  8'h30, 8'h03, ALU_SRL, 8'h80, 8'h02, 2'b01, 8'h33};
    tbl[11] = '{2'b00, ALU_ADD, 8'h00, 8'h00, ALU_ADD, 8'h00, 8'h00, 2'b00, 8'h00};
    rst = 1;
    drive(2'b11, ALU_ADD, 8'h00, 8'h00, ALU_ADD, 8'h00, 8'h00);
    repeat (2) begin
      @(negedge clk);
      chk("reset_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_result", rsp_result, 0);
      chk("reset_busy", busy, 0);
    end
    next();
    rst = 0;
    req_valid = 2'b00;
    for (int i = 0; i < 12; i++) begin
      next();
      drive(tbl[i].v, tbl[i].f0, tbl[i].a0, tbl[i].b0, tbl[i].f1, tbl[i].a1, tbl[i].b1);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy, 0);
      if (tbl[i].rdy != 2'b00) expect_rsp(tbl[i].rdy[1], tbl[i].res, 2);
    end
    repeat (2) next();
    next();
    drive(2'b10, ALU_ADD, 8'h01, 8'h02, ALU_MUL, 8'hF6, 8'h11);
    @(negedge clk);
    chk("mul_accept_ready", req_ready, 2'b10);
    expect_rsp(1'b1, 8'h56, MC + 1);
    next();
    drive(2'b01, ALU_ADD, 8'h01, 8'h02, ALU_MUL, 8'hF6, 8'h11);
    @(negedge clk);
    chk("mul_stall_busy", busy, 1);
    chk("mul_stall_ready", req_ready, 2'b00);
    next();
    @(negedge clk);
    chk("mul_after_ready", req_ready, 2'b01);
    chk("mul_after_busy", busy, 0);
    expect_rsp(1'b0, 8'h03, 2);
    next();
    req_valid = 2'b00;
    @(negedge clk);
    chk("mul_rsp", {rsp_valid, rsp_result}, {2'b10, 8'h56});
    next();
    @(negedge clk);
    chk("mul_next_rsp", {rsp_valid, rsp_result}, {2'b01, 8'h03});
    next();
    drive(2'b01, ALU_MUL, 8'h02, 8'h03, ALU_ADD, 8'h00, 8'h00);
    @(negedge clk);
    chk("rstmul_ready", req_ready, 2'b01);
    expect_rsp(1'b0, 8'h06, MC + 1);
    next();
    req_valid = 2'b00;
    rst = 1;
    next();
    rst = 0;
    @(negedge clk);
    chk("rstmul_busy", busy, 0);
    chk("rstmul_rsp", rsp_valid, 0);
    repeat (3) begin
      next();
      @(negedge clk);
      chk("rstmul_quiet", {busy, rsp_valid}, 0);
    end
    next();
    drive(2'b01, ALU_ADD, 8'h03, 8'h04, ALU_ADD, 8'h00, 8'h00);
    @(negedge clk);
    chk("rstmul_add_ready", req_ready, 2'b01);
    expect_rsp(1'b0, 8'h07, 2);
    next();
    req_valid = 2'b00;
    @(negedge clk);
    chk("rstmul_add_early", rsp_valid, 0);
    next();
    @(negedge clk);
    chk("rstmul_add_rsp", {rsp_valid, rsp_result}, {2'b01, 8'h07});
    next();
    drive(2'b01, ALU_MUL, 8'h03, 8'h05, ALU_ADD, 8'h11, 8'h22);
    @(negedge clk);
    chk("wd_mul_ready", req_ready, 2'b01);
    expect_rsp(1'b0, 8'h0F, MC + 1);
    next();
    req_valid = 2'b10;
    @(negedge clk);
    chk("wd_held_ready", req_ready, 2'b00);
    next();
    req_valid = 2'b00;
    @(negedge clk);
    chk("wd_drop_ready", req_ready, 2'b00);
    next();
    drive(2'b11, ALU_ADD, 8'h01, 8'h01, ALU_ADD, 8'h11, 8'h22);
    @(negedge clk);
    chk("wd_rr_ready", req_ready, 2'b10);
    expect_rsp(1'b1, 8'h33, 2);
    next();
    req_valid = 2'b00;
    repeat (4) next();
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
